// File: rtl/pulse_peak_extractor_if.sv
// Event readout bundle between the peak extractor FIFO and its consumer.
// The producer drives the head record and valid; the consumer drives ready.
interface pulse_peak_extractor_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 32,
    parameter int WW     = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_peak;
    logic [TS_W-1:0]   out_ts;
    logic [WW-1:0]     out_width;
    logic              out_pileup;

    modport master (
        output out_valid, out_peak, out_ts, out_width, out_pileup,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_peak, out_ts, out_width, out_pileup,
        output out_ready
    );
endinterface

// File: rtl/pulse_peak_extractor.sv
// Threshold pulse detector: tracks per-pulse maximum, its timestamp and width,
// and queues one event record per pulse with hold-off and pile-up flagging.
module pulse_peak_extractor #(
    parameter int DATA_W     = 16,
    parameter int TS_W       = 32,
    parameter int MAX_WIDTH  = 255,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] threshold,
    pulse_peak_extractor_if.master   out,
    output logic [7:0]               drop_count
);
    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [HW-1:0] HLOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
    localparam logic [WW-1:0] WMAX  = WW'(MAX_WIDTH);
    localparam logic [WW-1:0] WONE  = WW'(1);
    localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] peak;
        logic [TS_W-1:0]   ts;
        logic [WW-1:0]     width;
        logic              pileup;
    } event_t;

    typedef enum logic [1:0] {IDLE, ABOVE, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [TS_W-1:0]          ts_q;
    logic signed [DATA_W-1:0] peak_q, peak_d;
    logic [TS_W-1:0]          pts_q, pts_d;
    logic [WW-1:0]            width_q, width_d;
    logic                     pile_q, pile_d;
    logic [HW-1:0]            hcnt_q, hcnt_d;
    logic                     above;
    logic                     push;
    event_t                   push_ev;

    assign above = in_data > threshold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            peak_q  <= '0;
            pts_q   <= '0;
            width_q <= '0;
            pile_q  <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            peak_q  <= peak_d;
            pts_q   <= pts_d;
            width_q <= width_d;
            pile_q  <= pile_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        peak_d         = peak_q;
        pts_d          = pts_q;
        width_d        = width_q;
        pile_d         = pile_q;
        hcnt_d         = hcnt_q;
        push           = 1'b0;
        push_ev.peak   = peak_q;
        push_ev.ts     = pts_q;
        push_ev.width  = width_q;
        push_ev.pileup = pile_q;
        unique case (state_q)
            IDLE: begin
                if (above) begin
                    state_d = ABOVE;
                    peak_d  = in_data;
                    pts_d   = ts_q;
                    width_d = WONE;
                    pile_d  = (WONE == WMAX);
                end
            end
            ABOVE: begin
                if (above) begin
                    if (width_q != WMAX) width_d = width_q + 1'b1;
                    pile_d = (width_d == WMAX);
                    // strict compare keeps the earliest sample of a tied maximum
                    if (in_data > peak_q) begin
                        peak_d = in_data;
                        pts_d  = ts_q;
                    end
                end else begin
                    push = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hcnt_d  = HLOAD;
                    end
                end
            end
            HOLD: begin
                if (hcnt_q == '0) state_d = IDLE;
                else hcnt_d = hcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    event_t          mem [FIFO_DEPTH];
    event_t          head;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic            full, pop, wr;

    assign full = (cnt == CFULL);
    assign pop  = out.out_valid && out.out_ready;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= push_ev;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            drop_count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && !wr && drop_count != 8'hFF)
                drop_count <= drop_count + 1'b1;
        end
    end

    assign head           = mem[rptr];
    assign out.out_valid  = (cnt != '0);
    assign out.out_peak   = out.out_valid ? head.peak   : '0;
    assign out.out_ts     = out.out_valid ? head.ts     : '0;
    assign out.out_width  = out.out_valid ? head.width  : '0;
    assign out.out_pileup = out.out_valid ? head.pileup : 1'b0;
endmodule
